wb_la_master: RTL
=================

Name: wb_la_master

Overview:
- Wishbone classic master: the initiator end of the user-area Wishbone slave bus.
- Turns single commands, supplied by a valid/ready command port (typically fed from logic-analyzer probes or a test sequencer), into one read or write cycle to a Wishbone slave.
- Returns read data and status on a valid/ready response port.
- One transaction outstanding at a time; used in the user area to exercise and bring up Wishbone slaves without the management core.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for ack (only with WBM_TIMEOUT_EN); range 1 to 65535.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  AW  byte address.
- cmd_dat  in  DW  write data.
- cmd_sel  in  DW/8  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_dat  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timed out.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_sel_o  out  DW/8  Wishbone byte select.
- wbm_dat_i  in  DW  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset value of every registered output is 0: wbm_*_o, rsp_valid, rsp_dat, rsp_err. State resets to IDLE.
- cmd_ready = (state == IDLE) and not wb_rst_i, combinational.
- FSM states: IDLE, BUS, RESP.
- IDLE -> BUS on cmd_valid and cmd_ready at edge N:
  - cmd_we/adr/dat/sel are registered onto wbm_*_o.
  - wbm_cyc_o = wbm_stb_o = 1 from cycle N+1 (one-cycle command-to-bus latency).
- BUS: cyc, stb and all wbm_*_o are held stable until termination.
  - Ack termination: edge where wbm_ack_i = 1.
    - Next cycle: cyc = stb = 0, state RESP, rsp_valid = 1, rsp_err = 0.
    - rsp_dat = wbm_dat_i sampled at the ack edge for reads; rsp_dat = 0 for writes.
  - Minimum transaction: ack in the first BUS cycle gives rsp_valid two cycles after command acceptance.
- RESP: rsp_valid, rsp_dat and rsp_err are held until rsp_valid and rsp_ready.
  - On that edge: rsp_valid = 0, state IDLE, cmd_ready = 1 in the next cycle.
  - No back-to-back overlap: a new command is never accepted in the cycle the response is consumed.
- wbm_ack_i outside BUS is ignored: no state change, no response.
- wbm_we_o/adr_o/dat_o/sel_o retain their last values after the cycle ends; slaves must qualify them with stb.
- Reset mid-operation:
  - Next edge forces IDLE, cyc = stb = 0, rsp_valid = 0.
  - An in-flight transaction is discarded with no response.
  - An ack arriving in the reset cycle is ignored.

Optional Feature:
- Macro WBM_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - If ack has not arrived when the counter equals TIMEOUT_CYCLES-1: cycle is aborted (cyc = stb = 0 next cycle), state RESP, rsp_err = 1, rsp_dat = 0.
  - Ack in the same cycle as the timeout condition wins: normal response, rsp_err = 0.
- When undefined:
  - No counter is instantiated; BUS waits indefinitely.
  - rsp_err is tied to 0.

Decomposition:
- Package wb_la_master_pkg:
  - State enum (IDLE, BUS, RESP).
  - Default AW/DW constants.
  - TIMEOUT_W = 16.
- One natural sub-module: wb_la_master_timeout.
  - Counter with clear/enable inputs and an expired output.
  - Instantiated only under WBM_TIMEOUT_EN.

Test Plan:
- Write, zero-wait:
  - Stimulus: cmd_we = 1, adr = 0x3000_0004, dat = 0xDEAD_BEEF, sel = 0xF; slave acks in the first BUS cycle.
  - Required: cyc/stb high exactly 1 cycle with those values; rsp_valid 2 cycles after acceptance; rsp_dat = 0, rsp_err = 0.
- Read with wait states:
  - Stimulus: adr = 0x3000_0000; slave acks after 3 cycles with 0x1234_5678.
  - Required: cyc/stb high 4 cycles; rsp_dat = 0x1234_5678.
- Response backpressure:
  - Stimulus: rsp_ready held low 5 cycles, then raised.
  - Required: rsp_valid and rsp_dat stable for all 5 cycles; cmd_ready 0 throughout, 1 the cycle after the handshake.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: no ack.
  - Required: cyc drops after 8 BUS cycles; rsp_err = 1, rsp_dat = 0.
  - Repeat with ack on cycle 8: rsp_err = 0.
- Reset mid-BUS and stray ack:
  - Stimulus: wb_rst_i pulsed during BUS; separately, ack pulsed in IDLE.
  - Required: cyc = stb = 0 next cycle and no rsp_valid; the idle ack causes no response and no state change.

Source files
------------

// File: rtl/wb_la_master_pkg.sv
// Shared types and constants for the wb_la_master Wishbone classic master.
// The WBM_TIMEOUT_EN macro (see wb_la_master.sv) uses TIMEOUT_W for its counter.
package wb_la_master_pkg;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned TIMEOUT_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

endpackage

// File: rtl/wb_la_master_timeout.sv
// Ack-wait counter for wb_la_master; only instantiated when WBM_TIMEOUT_EN is defined.
module wb_la_master_timeout
  import wb_la_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Saturates at the limit so a stalled enable can never wrap back below it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_la_master.sv
// Wishbone classic master driven by a valid/ready command port, one transaction at a time.
// Define WBM_TIMEOUT_EN to abort cycles that see no ack within TIMEOUT_CYCLES.
module wb_la_master
  import wb_la_master_pkg::*;
#(
  parameter int unsigned AW             = DEFAULT_AW,
  parameter int unsigned DW             = DEFAULT_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,

  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_W) - 1) begin : g_bad_timeout
    $error("wb_la_master: TIMEOUT_CYCLES out of range");
  end

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_accept;
  logic              timeout_hit;

  assign cmd_ready  = (state_q == StIdle) && !wb_rst_i;
  assign cmd_accept = cmd_valid && cmd_ready;

`ifdef WBM_TIMEOUT_EN
  logic expired;

  wb_la_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (cmd_accept),
    .en      ((state_q == StBus) && !wbm_ack_i),
    .expired (expired)
  );

  assign timeout_hit = expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          state_d     = StResp;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule
